// File: rtl/soc_fabric_if.sv
// soc_fabric_if: CPU request channel plus shared slave request/response channel.
interface soc_fabric_if;
  logic         m_vld;
  logic [31:0]  m_addr;
  logic [3:0]   m_we;
  logic [31:0]  m_wdat;
  logic         m_rdy;
  logic [31:0]  m_rdat;
  logic [3:0]   s_vld;
  logic [31:0]  s_addr;
  logic [3:0]   s_we;
  logic [31:0]  s_wdat;
  logic [3:0]   s_rdy;
  logic [127:0] s_rdat;
  modport master (
    output m_vld, m_addr, m_we, m_wdat, s_rdy, s_rdat,
    input  m_rdy, m_rdat, s_vld, s_addr, s_we, s_wdat
  );
  modport slave (
    input  m_vld, m_addr, m_we, m_wdat, s_rdy, s_rdat,
    output m_rdy, m_rdat, s_vld, s_addr, s_we, s_wdat
  );
endinterface

// File: rtl/soc_fabric.sv
// soc_fabric: single-outstanding CPU-to-4-slave decoder with timeout and error reporting.
module soc_fabric #(
  parameter int unsigned TIMEOUT_CYC = 255,
  parameter logic [31:0] ERR_RDATA   = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        arst_n,
  soc_fabric_if.slave bus,
  output logic        err_pulse,
  output logic [7:0]  err_cnt
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t      state;
  logic [31:0] tcnt;
  logic [1:0]  tgt;
  logic        rdy_hit;
  logic        tout;
  logic [7:0]  err_nxt;
  // The registered address carries the target, so no separate target register is needed.
  assign tgt     = bus.s_addr[29:28];
  assign rdy_hit = bus.s_rdy[tgt];
  assign tout    = (TIMEOUT_CYC != 0) && (tcnt + 32'd1 == TIMEOUT_CYC);
  assign err_nxt = err_cnt + {7'd0, err_cnt != 8'hFF};
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state      <= IDLE;
      tcnt       <= '0;
      bus.m_rdy  <= 1'b0;
      bus.m_rdat <= '0;
      bus.s_vld  <= '0;
      bus.s_addr <= '0;
      bus.s_we   <= '0;
      bus.s_wdat <= '0;
      err_pulse  <= 1'b0;
      err_cnt    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.m_vld) begin
          bus.s_addr <= bus.m_addr;
          bus.s_we   <= bus.m_we;
          bus.s_wdat <= bus.m_wdat;
          tcnt       <= '0;
          if (bus.m_addr[31:30] == 2'b00) begin
            state     <= BUSY;
            bus.s_vld <= 4'b0001 << bus.m_addr[29:28];
          end else begin
            state      <= RESP;
            bus.m_rdy  <= 1'b1;
            bus.m_rdat <= ERR_RDATA;
            err_pulse  <= 1'b1;
            err_cnt    <= err_nxt;
          end
        end
        BUSY: if (rdy_hit) begin
          state      <= RESP;
          bus.s_vld  <= '0;
          bus.m_rdy  <= 1'b1;
          bus.m_rdat <= bus.s_rdat[{tgt, 5'd0} +: 32];
        end else if (tout) begin
          state      <= RESP;
          bus.s_vld  <= '0;
          bus.m_rdy  <= 1'b1;
          bus.m_rdat <= ERR_RDATA;
          err_pulse  <= 1'b1;
          err_cnt    <= err_nxt;
        end else begin
          tcnt <= tcnt + 32'd1;
        end
        default: begin
          state     <= IDLE;
          bus.m_rdy <= 1'b0;
          err_pulse <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_soc_fabric.sv
// tb_soc_fabric: scenario tasks with a response scoreboard for soc_fabric (TIMEOUT_CYC=4).
module tb_soc_fabric;
  logic       clk = 1'b0;
  logic       arst_n = 1'b0;
  logic       err_pulse;
  logic [7:0] err_cnt;
  int checks = 0;
  int failures = 0;
  typedef struct {logic [31:0] rdat; logic err;} exp_t;
  exp_t sb[$];
  exp_t e;
  localparam logic [31:0] ERR = 32'hDEAD_BEEF;

  soc_fabric_if bus();
  soc_fabric #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .arst_n(arst_n), .bus(bus.slave), .err_pulse(err_pulse), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [31:0] a, input logic [3:0] we, input logic [31:0] wd);
    bus.m_vld = 1'b1; bus.m_addr = a; bus.m_we = we; bus.m_wdat = wd;
  endtask

  task automatic test_reset();
    arst_n = 1'b0; bus.m_vld = 1'b0; bus.m_addr = '0; bus.m_we = '0; bus.m_wdat = '0;
    bus.s_rdy = '0; bus.s_rdat = '0;
    repeat (2) @(negedge clk);
    checks++; if ({bus.m_rdy, bus.s_vld, err_pulse, err_cnt, bus.s_we} !== 18'd0) begin failures++; $display("FAIL rst_ctrl got %h exp 0", {bus.m_rdy, bus.s_vld, err_pulse, err_cnt, bus.s_we}); end
    checks++; if ({bus.s_addr, bus.s_wdat, bus.m_rdat} !== 96'd0) begin failures++; $display("FAIL rst_data got %h exp 0", {bus.s_addr, bus.s_wdat, bus.m_rdat}); end
  endtask

  task automatic test_read();
    drive(32'h2000_0010, 4'h0, 32'h0);
    bus.s_rdat[95:64] = 32'h1234_5678; bus.s_rdy = 4'b0100;
    sb.push_back('{32'h1234_5678, 1'b0});
    arst_n = 1'b1;
    @(negedge clk);
    checks++; if (bus.s_vld !== 4'b0100) begin failures++; $display("FAIL rd_svld got %h exp 4", bus.s_vld); end
    checks++; if (bus.s_addr !== 32'h2000_0010) begin failures++; $display("FAIL rd_saddr got %h exp 20000010", bus.s_addr); end
    checks++; if (bus.m_rdy !== 1'b0) begin failures++; $display("FAIL rd_early_rdy got %b exp 0", bus.m_rdy); end
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (bus.m_rdy !== 1'b1) begin failures++; $display("FAIL rd_lat got m_rdy=%b exp 1", bus.m_rdy); end
    checks++; if (bus.m_rdat !== e.rdat) begin failures++; $display("FAIL rd_data got %h exp %h", bus.m_rdat, e.rdat); end
    checks++; if ({bus.s_vld, err_pulse} !== {4'b0000, e.err}) begin failures++; $display("FAIL rd_post got %h exp %h", {bus.s_vld, err_pulse}, {4'b0000, e.err}); end
    bus.m_vld = 1'b0; bus.s_rdy = '0;
    @(negedge clk);
    checks++; if (bus.m_rdy !== 1'b0) begin failures++; $display("FAIL rd_one_pulse got %b exp 0", bus.m_rdy); end
  endtask

  task automatic test_write();
    drive(32'h1000_0000, 4'hF, 32'hA5A5_A5A5);
    bus.s_rdat[63:32] = 32'h0BAD_F00D; bus.s_rdy = 4'b1101;
    sb.push_back('{32'h0BAD_F00D, 1'b0});
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++; if ({bus.s_vld, bus.s_addr, bus.s_we, bus.s_wdat, bus.m_rdy} !== {4'b0010, 32'h1000_0000, 4'hF, 32'hA5A5_A5A5, 1'b0}) begin failures++; $display("FAIL wr_stable%0d got %h", i, {bus.s_vld, bus.s_addr, bus.s_we, bus.s_wdat, bus.m_rdy}); end
    end
    bus.s_rdy = 4'b0010;
    @(negedge clk);
    e = sb.pop_front();
    checks++; if (bus.m_rdy !== 1'b1) begin failures++; $display("FAIL wr_rdy got %b exp 1", bus.m_rdy); end
    checks++; if (bus.m_rdat !== e.rdat) begin failures++; $display("FAIL wr_data got %h exp %h", bus.m_rdat, e.rdat); end
    checks++; if ({bus.s_vld, err_pulse, err_cnt} !== {4'b0000, e.err, 8'd0}) begin failures++; $display("FAIL wr_post got %h exp 0", {bus.s_vld, err_pulse, err_cnt}); end
    bus.m_vld = 1'b0; bus.s_rdy = '0;
    @(negedge clk);
    checks++; if ({bus.m_rdy, bus.s_vld} !== 5'd0) begin failures++; $display("FAIL wr_one_pulse got %h exp 0", {bus.m_rdy, bus.s_vld}); end
  endtask

  task automatic test_unmapped();
    drive(32'h8000_0000, 4'h0, 32'h0);
    sb.push_back('{ERR, 1'b1});
    @(negedge clk);
    e = sb.pop_front();
    checks++; if ({bus.m_rdy, bus.s_vld} !== 5'b1_0000) begin failures++; $display("FAIL um_rdy got %h exp 10", {bus.m_rdy, bus.s_vld}); end
    checks++; if (bus.m_rdat !== e.rdat) begin failures++; $display("FAIL um_data got %h exp %h", bus.m_rdat, e.rdat); end
    checks++; if ({err_pulse, err_cnt} !== {e.err, 8'd1}) begin failures++; $display("FAIL um_err got %h exp %h", {err_pulse, err_cnt}, {e.err, 8'd1}); end
    bus.m_vld = 1'b0;
    @(negedge clk);
    checks++; if ({bus.m_rdy, err_pulse} !== 2'b00) begin failures++; $display("FAIL um_pulse got %b exp 00", {bus.m_rdy, err_pulse}); end
  endtask

  task automatic test_timeout();
    int hi = 0;
    int lat = -1;
    drive(32'h0000_0040, 4'h0, 32'h0);
    bus.s_rdy = 4'b1110;
    sb.push_back('{ERR, 1'b1});
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.m_rdy) begin lat = i; break; end
      if (bus.s_vld == 4'b0001) hi++;
    end
    e = sb.pop_front();
    checks++; if (lat !== 5) begin failures++; $display("FAIL to_lat got %0d exp 5", lat); end
    checks++; if (hi !== 4) begin failures++; $display("FAIL to_svld_cycles got %0d exp 4", hi); end
    checks++; if ({bus.s_vld, bus.m_rdat} !== {4'b0000, e.rdat}) begin failures++; $display("FAIL to_data got %h exp %h", {bus.s_vld, bus.m_rdat}, {4'b0000, e.rdat}); end
    checks++; if ({err_pulse, err_cnt} !== {e.err, 8'd2}) begin failures++; $display("FAIL to_err got %h exp %h", {err_pulse, err_cnt}, {e.err, 8'd2}); end
    bus.m_vld = 1'b0; bus.s_rdy = '0;
    @(negedge clk);
  endtask

  task automatic test_race();
    drive(32'h3000_0000, 4'h0, 32'h0);
    bus.s_rdat[127:96] = 32'hCAFE_0003; bus.s_rdy = '0;
    sb.push_back('{32'hCAFE_0003, 1'b0});
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      checks++; if ({bus.s_vld, bus.m_rdy} !== 5'b1000_0) begin failures++; $display("FAIL race_busy%0d got %h exp 10", i, {bus.s_vld, bus.m_rdy}); end
    end
    bus.s_rdy = 4'b1000;
    @(negedge clk);
    e = sb.pop_front();
    checks++; if ({bus.m_rdy, bus.m_rdat} !== {1'b1, e.rdat}) begin failures++; $display("FAIL race_data got %h exp %h", {bus.m_rdy, bus.m_rdat}, {1'b1, e.rdat}); end
    checks++; if ({err_pulse, err_cnt} !== {e.err, 8'd2}) begin failures++; $display("FAIL race_err got %h exp %h", {err_pulse, err_cnt}, {e.err, 8'd2}); end
    bus.m_vld = 1'b0; bus.s_rdy = '0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int t[2];
    int n = 0;
    bus.s_rdat[31:0] = 32'h0000_B2B0; bus.s_rdy = 4'b0001;
    drive(32'h4000_0000, 4'h0, 32'h0);
    sb.push_back('{ERR, 1'b1});
    sb.push_back('{32'h0000_B2B0, 1'b0});
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.m_rdy) begin
        e = sb.pop_front();
        checks++; if ({bus.m_rdat, err_pulse} !== {e.rdat, e.err}) begin failures++; $display("FAIL b2b_resp%0d got %h exp %h", n, {bus.m_rdat, err_pulse}, {e.rdat, e.err}); end
        t[n] = i;
        n++;
        if (n == 1) drive(32'h0000_0008, 4'h3, 32'h0000_0001);
        else begin bus.m_vld = 1'b0; break; end
      end
    end
    checks++; if (n !== 2) begin failures++; $display("FAIL b2b_count got %0d exp 2", n); end
    checks++; if ({t[0], t[1]} !== {32'd1, 32'd4}) begin failures++; $display("FAIL b2b_timing got %0d,%0d exp 1,4", t[0], t[1]); end
    checks++; if (err_cnt !== 8'd3) begin failures++; $display("FAIL b2b_errcnt got %0d exp 3", err_cnt); end
    bus.m_vld = 1'b0; bus.s_rdy = '0;
    @(negedge clk);
  endtask

  task automatic test_reset_busy();
    int bad = 0;
    drive(32'h1000_0004, 4'h0, 32'h0);
    bus.s_rdy = '0;
    @(negedge clk);
    checks++; if (bus.s_vld !== 4'b0010) begin failures++; $display("FAIL rb_busy got %h exp 2", bus.s_vld); end
    #2 arst_n = 1'b0;
    #1;
    checks++; if ({bus.m_rdy, bus.s_vld, err_pulse, err_cnt} !== 14'd0) begin failures++; $display("FAIL rb_async_ctrl got %h exp 0", {bus.m_rdy, bus.s_vld, err_pulse, err_cnt}); end
    checks++; if ({bus.s_addr, bus.s_we, bus.s_wdat, bus.m_rdat} !== 100'd0) begin failures++; $display("FAIL rb_async_data got %h exp 0", {bus.s_addr, bus.s_we, bus.s_wdat, bus.m_rdat}); end
    bus.m_vld = 1'b0;
    @(negedge clk);
    arst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (bus.m_rdy || err_pulse || err_cnt != 8'd0) bad++;
    end
    checks++; if (bad !== 0) begin failures++; $display("FAIL rb_after_release got %0d bad cycles exp 0", bad); end
  endtask

  task automatic test_saturate();
    int n = 0;
    drive(32'hF000_0000, 4'h0, 32'h0);
    for (int i = 1; i <= 700; i++) begin
      @(negedge clk);
      if (bus.m_rdy) begin
        n++;
        if (n == 254) begin
          checks++; if (err_cnt !== 8'hFE) begin failures++; $display("FAIL sat_254 got %h exp fe", err_cnt); end
        end
        if (n == 300) begin bus.m_vld = 1'b0; break; end
      end
    end
    checks++; if (n !== 300) begin failures++; $display("FAIL sat_count got %0d exp 300", n); end
    checks++; if (err_cnt !== 8'hFF) begin failures++; $display("FAIL sat_final got %h exp ff", err_cnt); end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_timeout();
    test_race();
    test_back_to_back();
    test_reset_busy();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/soc_fabric.md
SOC_FABRIC -- requirements
Module: soc_fabric

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: BUSY-state cycles before abort; 0 disables the timeout.
REQ-002 SHALL have parameter ERR_RDATA, default 32'hDEAD_BEEF: read data returned on an error response.
REQ-003 SHALL have one clock and an asynchronous, active-low reset; ports arst_n and clk.
REQ-004 arst_n  in  1  asynchronous active-low reset.
REQ-005 clk  in  1  bus clock; all state changes on its rising edge.
REQ-006 m_vld  in  1  upstream (CPU) request valid; held until m_rdy.
REQ-007 m_addr  in  32  request address.
REQ-008 m_we  in  4  byte write enables; |m_we=1 write, else read.
REQ-009 m_wdat  in  32  write data.
REQ-010 m_rdy  out  1  single-cycle completion acknowledge to upstream.
REQ-011 m_rdat  out  32  read data, valid while m_rdy=1.
REQ-012 s_vld  out  4  one-hot per-slave request valid.
REQ-013 s_addr  out  32  registered request address, shared by all slaves.
REQ-014 s_we  out  4  registered byte enables, shared.
REQ-015 s_wdat  out  32  registered write data, shared.
REQ-016 s_rdy  in  4  per-slave acknowledge.
REQ-017 s_rdat  in  128  per-slave read data; slave k on bits [32k+31:32k].
REQ-018 err_pulse  out  1  one-cycle pulse per error response.
REQ-019 err_cnt  out  8  saturating error count.

Function
REQ-020 SHALL implement an FSM with states IDLE, BUSY and RESP.
REQ-021 In IDLE with m_vld=1, SHALL register m_addr, m_we and m_wdat; target = m_addr[31:28]; values 0..3 select slave 0..3, any other value is unmapped.
REQ-022 For a mapped target: IDLE->BUSY; s_vld[target]=1 from the next cycle; all other s_vld bits = 0.
REQ-023 For an unmapped target: IDLE->RESP directly, flagged as an error; no s_vld bit asserted.
REQ-024 In BUSY, s_vld and the s_* fields SHALL remain stable until s_rdy[target]=1; s_rdy of non-selected slaves SHALL be ignored.
REQ-025 In BUSY with s_rdy[target]=1: capture s_rdat slice of target into the read-data register (writes included), drop s_vld in the next cycle, go BUSY->RESP.
REQ-026 In RESP: m_rdy=1 for exactly one cycle, m_rdat = captured data (ERR_RDATA if error), then RESP->IDLE unconditionally.
REQ-027 SHALL not sample m_vld in RESP; back-to-back requests are accepted from IDLE only, one cycle after m_rdy.
REQ-028 Minimum latency, mapped target with s_rdy=1 in the first BUSY cycle: m_vld accepted at edge N, m_rdy high in cycle N+2.
REQ-029 Timeout counter SHALL clear on IDLE->BUSY and increment each BUSY cycle without s_rdy[target].
REQ-030 When the timeout counter reaches TIMEOUT_CYC (nonzero) without s_rdy: abort, s_vld=0 next cycle, BUSY->RESP flagged as an error.
REQ-031 If s_rdy[target] and timeout occur in the same cycle, s_rdy SHALL win: normal response, no error.
REQ-032 err_pulse=1 during the RESP cycle of an error response only.
REQ-033 err_cnt SHALL increment by 1 per error response and saturate at 8'hFF.
REQ-034 m_rdy, s_vld and err_pulse SHALL be driven only from registers; no combinational path from any input to them.

Reset
REQ-035 On arst_n=0, asynchronously: FSM=IDLE, m_rdy=0, m_rdat=0, s_vld=0, s_addr=0, s_we=0, s_wdat=0, err_pulse=0, err_cnt=0, timeout counter=0.
REQ-036 Reset in BUSY or RESP SHALL abandon the transaction: no m_rdy pulse and no error count after reset release.
REQ-037 First request SHALL be accepted on the first rising clk edge with arst_n=1 and m_vld=1.

Verification
REQ-038 Read from addr 0x2000_0010, s_rdy[2]=1 in the first BUSY cycle, s_rdat slice 2 = 0x1234_5678 -> s_vld=4'b0100 for one cycle; m_rdy in cycle N+2; m_rdat=0x1234_5678.
REQ-039 Write to 0x1000_0000, we=4'hF, wdat=0xA5A5_A5A5, s_rdy[1] delayed 3 cycles -> s_* fields stable throughout; one m_rdy pulse; s_vld cleared after s_rdy.
REQ-040 Access to 0x8000_0000 -> no s_vld asserted; m_rdy in cycle N+1; m_rdat=0xDEAD_BEEF; err_pulse=1; err_cnt=1.
REQ-041 TIMEOUT_CYC=4, slave 0 never ready -> s_vld[0] high 4 cycles then dropped; m_rdat=0xDEAD_BEEF; err_cnt increments; s_rdy arriving in the same cycle as timeout -> normal response, no error.
REQ-042 arst_n pulsed low in BUSY -> all outputs reset immediately; no m_rdy after release; 300 unmapped accesses -> err_cnt=8'hFF.
